fetch_fifo: RTL
===============

# fetch_fifo

Instruction fetch buffer between the IF1 stage and decode. Accepts one fetch packet per cycle from IF1: PC, a 64-bit instruction pair, badv, exception code and cookie. It normalizes each packet so that slot 0 always holds the instruction at the packet PC, and stores it in a circular buffer. Decode pops whole packets through a valid/ready handshake. A flush input discards all buffered packets on redirect.

## Interface
Parameters:
- DEPTH, 8, number of packet entries; power of two, ≥ 2
- CW, $clog2(DEPTH)+1, width of `count`

Ports:
- clk  in  1  single clock, rising edge
- rstn  in  1  reset; asynchronous and active-high
- flush  in  1  discard all entries this cycle
- in_valid  in  1  IF1 presents a packet
- in_ready  out  1  buffer can accept a packet; equals !full
- in_pc  in  32  fetch PC of the packet
- in_inst0  in  32  rdata[31:0]
- in_inst1  in  32  rdata[63:32]
- in_badv  in  32  faulting address
- in_exception  in  7  exception code; 0 = none
- in_cookie  in  32  icache cookie, passed through
- out_valid  out  1  head entry present; equals !empty
- out_ready  in  1  decode accepts the head packet
- out_pc0, out_pc1  out  32 each  PC of slot 0 and slot 1
- out_inst0, out_inst1  out  32 each  slot instructions
- out_slot_valid  out  2  bit i set = slot i is valid
- out_badv  out  32  head badv
- out_exception  out  7  head exception code
- out_cookie  out  32  head cookie
- count  out  CW  number of occupied entries

## Operation
- Push condition: in_valid & in_ready & !flush.
- Pop condition: out_valid & out_ready & !flush.
- Normalization is applied on write, and stored entries are already normalized:
  - in_pc[2]=0, in_exception=0: inst0←in_inst0, inst1←in_inst1, slot_valid=2'b11.
  - in_pc[2]=1: inst0←in_inst1, inst1←32'h0, slot_valid=2'b01.
  - in_exception≠0: slot_valid=2'b01 regardless of pc[2]. inst0 is selected by the pc[2] rule above.
  - pc0←in_pc; pc1←in_pc+4 (32-bit wrap). badv, exception and cookie are stored unmodified.
- Storage is a circular buffer with read and write pointers of $clog2(DEPTH) bits each. Pointers wrap from DEPTH-1 to 0.
- count is updated on every accepted operation:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
- full = (count==DEPTH); empty = (count==0).
- in_ready depends only on registered state. A push is refused when the buffer is full, even if a pop occurs in the same cycle; this prevents any ready combinational path from decode back to IF1.
- Simultaneous push and pop when the buffer is neither full nor empty: both take effect and count is unchanged.
- Push while empty: the entry becomes visible on the next cycle; there is no same-cycle bypass.
- flush clears both pointers and count in the next cycle. Flush overrides push and pop in the same cycle, so neither takes effect.
- Out fields read the head entry combinationally (first-word fall-through). Out fields are don't-care while out_valid=0. The bench checks them only when out_valid=1.
- Reset, including assertion mid-operation: rptr=wptr=0 and count=0, which gives out_valid=0, in_ready=1 and count=0. Entry storage is not reset.

## Timing
- Latency from push at edge N to out_valid=1 is one cycle: the entry is visible after edge N.
- Throughput: one push and one pop per cycle sustained, provided the buffer is not full.
- After flush at edge N, out_valid=0 and in_ready=1 from edge N onward.
- All outputs derive from registers, plus the head-entry read mux. There are no input-to-output combinational paths.

## Structure
- A shared package, `fetch_pkg`, holds:
  - the `fetch_entry_t` struct: pc0, pc1, inst0, inst1, slot_valid, badv, exception, cookie
  - the `EXC_NONE` = 7'd0 constant
- One sub-module, `fetch_norm`, implements the combinational normalization from the input fields to `fetch_entry_t`.
- The top level contains the pointers, count and entry array.

## Test plan
- **Reset:** assert rstn mid-stream with 3 entries held → count=0, out_valid=0, in_ready=1 in the same cycle, asynchronously.
- **Aligned packet:** push pc=32'h1c000000, inst0=32'h02800401, inst1=32'h02800802 → next cycle:
  - out_slot_valid=2'b11
  - out_pc1=32'h1c000004
  - out_inst1=32'h02800802
- **Odd-word packet:** push pc=32'h1c000004 with inst1=32'hDEADBEEF → out_inst0=32'hDEADBEEF, out_slot_valid=2'b01.
- **Exception packet:** push pc=32'h1c000000 with exception=7'h08 → out_slot_valid=2'b01, out_exception=7'h08.
- **Full with simultaneous pop:**
  - Fill 8 entries with out_ready=0 → in_ready=0, count=8.
  - Then pop with in_valid=1 → the push is refused and count=7.
  - Following cycle: push and pop together → count stays 7, and FIFO order is preserved across the pointer wrap.
- **Flush:** 5 entries held; flush=1 with in_valid=1 and out_ready=1 in the same cycle → count=0 next cycle and the pushed packet is dropped.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch buffer: the normalized packet entry
// and the "no exception" code.
package fetch_pkg;

    localparam logic [6:0] EXC_NONE = 7'd0;

    typedef struct packed {
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic [31:0] inst0;
        logic [31:0] inst1;
        logic [1:0]  slot_valid;
        logic [31:0] badv;
        logic [6:0]  exception;
        logic [31:0] cookie;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_norm.sv
// Combinational packet normalization: slot 0 always holds the instruction at
// the packet PC; odd-word or faulting packets carry only one valid slot.
module fetch_norm
    import fetch_pkg::*;
(
    input  logic [31:0]  i_pc,
    input  logic [31:0]  i_inst0,
    input  logic [31:0]  i_inst1,
    input  logic [31:0]  i_badv,
    input  logic [6:0]   i_exception,
    input  logic [31:0]  i_cookie,
    output fetch_entry_t o_entry
);

    logic w_odd;
    logic w_exc;

    assign w_odd = i_pc[2];
    assign w_exc = (i_exception != EXC_NONE);

    always_comb begin
        o_entry            = '0;
        o_entry.pc0        = i_pc;
        o_entry.pc1        = i_pc + 32'd4;
        o_entry.inst0      = w_odd ? i_inst1 : i_inst0;
        o_entry.inst1      = w_odd ? 32'h0 : i_inst1;
        // A fault ends the packet at slot 0 whatever the word alignment.
        o_entry.slot_valid = (w_odd || w_exc) ? 2'b01 : 2'b11;
        o_entry.badv       = i_badv;
        o_entry.exception  = i_exception;
        o_entry.cookie     = i_cookie;
    end

endmodule

// File: rtl/fetch_fifo.sv
// Fetch buffer between IF1 and decode: circular buffer of normalized packets
// with first-word fall-through read and a registered-only in_ready.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_inst0,
    input  logic [31:0]   in_inst1,
    input  logic [31:0]   in_badv,
    input  logic [6:0]    in_exception,
    input  logic [31:0]   in_cookie,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_pc0,
    output logic [31:0]   out_pc1,
    output logic [31:0]   out_inst0,
    output logic [31:0]   out_inst1,
    output logic [1:0]    out_slot_valid,
    output logic [31:0]   out_badv,
    output logic [6:0]    out_exception,
    output logic [31:0]   out_cookie,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    fetch_entry_t  r_mem [DEPTH];

    fetch_entry_t  w_entry;
    fetch_entry_t  w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    fetch_norm u_norm (
        .i_pc        (in_pc),
        .i_inst0     (in_inst0),
        .i_inst1     (in_inst1),
        .i_badv      (in_badv),
        .i_exception (in_exception),
        .i_cookie    (in_cookie),
        .o_entry     (w_entry)
    );

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    // Push looks only at the registered full flag, so a same-cycle pop never frees a slot.
    assign w_push  = in_valid & ~w_full & ~flush;
    assign w_pop   = ~w_empty & out_ready & ~flush;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= w_entry;
    end

    assign w_head         = r_mem[r_rptr];
    assign in_ready       = ~w_full;
    assign out_valid      = ~w_empty;
    assign out_pc0        = w_head.pc0;
    assign out_pc1        = w_head.pc1;
    assign out_inst0      = w_head.inst0;
    assign out_inst1      = w_head.inst1;
    assign out_slot_valid = w_head.slot_valid;
    assign out_badv       = w_head.badv;
    assign out_exception  = w_head.exception;
    assign out_cookie     = w_head.cookie;
    assign count          = r_count;

endmodule
